uart_tx_sequencer: RTL and testbench

UART transmit controller that sequences a programmable bit-period counter and a serializer to send 8N1 frames (optional even parity) on a single serial line. It sits between on-chip byte producers, using a valid/ready handshake, and the board TX pin. It owns the baud timing: the bit period is a runtime-configurable divisor of the system clock, reset from parameters.

---
 rtl/uart_tx_sequencer.sv | 159 +++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART 8N1 transmit sequencer with runtime baud divisor; UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_sequencer #(
    parameter int CLOCKS_PER_SECOND = 100_000_000,
    parameter int BAUD              = 115200
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [15:0] cfg_divisor,
    input  logic        cfg_write,
    output logic        tx,
    output logic        busy
);

    localparam int          RESET_DIV_INT = CLOCKS_PER_SECOND / BAUD;
    localparam logic [15:0] RESET_DIV     = (RESET_DIV_INT < 2) ? 16'd2 : RESET_DIV_INT[15:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cfg_div_q, cfg_div_d;
    logic        tx_q, tx_d;
    logic        tx_ready_q, tx_ready_d;
    logic        busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif
    logic        bit_end;

    // A bit period shorter than two cycles cannot be sequenced, so it is widened.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

    assign bit_end = (cnt_q == div_q - 16'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            div_q      <= RESET_DIV;
            cfg_div_q  <= RESET_DIV;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            cfg_div_q  <= cfg_div_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        cfg_div_d = cfg_write ? clamp_div(cfg_divisor) : cfg_div_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        div_d     = div_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = tx_data;
                    // cfg_div_d already reflects a same-cycle write, giving the bypass.
                    div_d   = cfg_div_d;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with it.
    always_comb begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b0;
        busy_d     = 1'b1;
        unique case (state_d)
            S_IDLE: begin
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - randomized self-checking bench for uart_tx_sequencer against a frame-level model
module tb_uart_tx_sequencer;

    localparam int CPS  = 100;
    localparam int BAUD = 10;
    localparam int DIV0 = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] cfg_divisor;
    logic        cfg_write;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic tx_s[$];
    logic busy_s[$];
    logic rdy_s[$];

    always #5 clock = ~clock;

    uart_tx_sequencer #(.CLOCKS_PER_SECOND(CPS), .BAUD(BAUD)) dut (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .cfg_divisor(cfg_divisor), .cfg_write(cfg_write),
        .tx(tx), .busy(busy)
    );

    // Line level in cycle c (1 = first cycle after the handshake edge) of a frame.
    function automatic logic exp_tx(input logic [7:0] d, input int div, input int c);
        int k;
        if (c < 1) return 1'b1;
        k = (c - 1) / div;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (NBITS == 11 && k == 9) return ^d;
        return 1'b1;
    endfunction

    function automatic logic [2:0] exp_pins(input logic [7:0] d, input int div, input int c);
        logic in_frame;
        in_frame = (c >= 1) && (c <= NBITS * div);
        return {exp_tx(d, div, c), in_frame, !in_frame};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input logic w, input logic [15:0] v);
        wait_ready();
        tx_data     = d;
        tx_valid    = 1'b1;
        cfg_write   = w;
        cfg_divisor = v;
        @(posedge clock);
        #1;
        tx_valid  = 1'b0;
        cfg_write = 1'b0;
    endtask

    task automatic capture(input int n, input int cfg_at, input logic [15:0] v);
        tx_s.delete(); busy_s.delete(); rdy_s.delete();
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            tx_s.push_back(tx); busy_s.push_back(busy); rdy_s.push_back(tx_ready);
            if (c == cfg_at) begin
                cfg_divisor = v;
                cfg_write   = 1'b1;
            end else begin
                cfg_write = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tx_valid = 1'b0; tx_data = '0; cfg_write = 1'b0; cfg_divisor = '0;
        repeat (3) @(negedge clock);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_frames();
        logic [7:0] d;
        logic [2:0] e;
        for (int i = 0; i < 5; i++) begin
            d = (i == 0) ? 8'hA5 : (i == 1) ? 8'h01 : 8'($urandom);
            start_frame(d, 1'b0, 16'd0);
            capture(NBITS * DIV0 + 1, 0, 16'd0);
            for (int c = 1; c <= NBITS * DIV0 + 1; c++) begin
                e = exp_pins(d, DIV0, c);
                checks++;
                if ({tx_s[c-1], busy_s[c-1], rdy_s[c-1]} !== e) begin
                    errors++;
                    $display("FAIL frame d=%h cycle %0d: {tx,busy,ready}=%b required %b", d, c,
                             {tx_s[c-1], busy_s[c-1], rdy_s[c-1]}, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int F = NBITS * DIV0;
        logic [2:0] e;
        int run;
        wait_ready();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clock);
        #1 tx_data = 8'hFF;
        capture(2 * F + 1, 0, 16'd0);
        tx_valid = 1'b0;
        for (int c = 1; c <= 2 * F + 1; c++) begin
            e = (c <= F + 1) ? exp_pins(8'h00, DIV0, c) : exp_pins(8'hFF, DIV0, c - (F + 1));
            checks++;
            if ({tx_s[c-1], busy_s[c-1], rdy_s[c-1]} !== e) begin
                errors++;
                $display("FAIL b2b cycle %0d: {tx,busy,ready}=%b required %b", c,
                         {tx_s[c-1], busy_s[c-1], rdy_s[c-1]}, e);
            end
        end
        run = 0;
        for (int c = F + 1; c >= 1 && tx_s[c-1] === 1'b1; c--) run++;
        checks++;
        if (run != DIV0 + 1) begin
            errors++;
            $display("FAIL b2b_stop_len: got %0d cycles, required %0d", run, DIV0 + 1);
        end
        wait_ready();
    endtask

    task automatic test_runtime_divisor();
        int divs[3] = '{10, 4, 2};
        logic [7:0] d;
        logic [2:0] e;
        for (int j = 0; j < 3; j++) begin
            d = 8'($urandom);
            if (j == 2) begin
                cfg_divisor = 16'd0;
                cfg_write   = 1'b1;
                @(negedge clock);
                cfg_write = 1'b0;
            end
            start_frame(d, 1'b0, 16'd0);
            capture(NBITS * divs[j] + 1, (j == 0) ? 30 : 0, 16'd4);
            for (int c = 1; c <= NBITS * divs[j] + 1; c++) begin
                e = exp_pins(d, divs[j], c);
                checks++;
                if ({tx_s[c-1], busy_s[c-1], rdy_s[c-1]} !== e) begin
                    errors++;
                    $display("FAIL divisor div=%0d cycle %0d: {tx,busy,ready}=%b required %b", divs[j], c,
                             {tx_s[c-1], busy_s[c-1], rdy_s[c-1]}, e);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] d;
        logic [2:0] e;
        d = 8'($urandom);
        start_frame(d, 1'b1, 16'd6);
        capture(NBITS * 6 + 1, 0, 16'd0);
        for (int c = 1; c <= NBITS * 6 + 1; c++) begin
            e = exp_pins(d, 6, c);
            checks++;
            if ({tx_s[c-1], busy_s[c-1], rdy_s[c-1]} !== e) begin
                errors++;
                $display("FAIL same_cycle cycle %0d: {tx,busy,ready}=%b required %b", c,
                         {tx_s[c-1], busy_s[c-1], rdy_s[c-1]}, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] e;
        start_frame(8'($urandom), 1'b0, 16'd0);
        capture(27, 0, 16'd0);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({tx, busy, tx_ready} !== 3'b101) begin
            errors++;
            $display("FAIL reset_mid_frame: {tx,busy,ready}=%b required 101", {tx, busy, tx_ready});
        end
        repeat (2) @(negedge clock);
        checks++;
        if ({tx, busy, tx_ready} !== 3'b101) begin
            errors++;
            $display("FAIL reset_hold: {tx,busy,ready}=%b required 101", {tx, busy, tx_ready});
        end
        reset_n = 1'b1;
        @(negedge clock);
        start_frame(8'h3C, 1'b0, 16'd0);
        capture(NBITS * DIV0 + 1, 0, 16'd0);
        for (int c = 1; c <= NBITS * DIV0 + 1; c++) begin
            e = exp_pins(8'h3C, DIV0, c);
            checks++;
            if ({tx_s[c-1], busy_s[c-1], rdy_s[c-1]} !== e) begin
                errors++;
                $display("FAIL post_reset cycle %0d: {tx,busy,ready}=%b required %b", c,
                         {tx_s[c-1], busy_s[c-1], rdy_s[c-1]}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_runtime_divisor();
        test_same_cycle();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
